branch_cmp_seq: RTL and testbench

Sequential RV32I branch-condition unit that resolves BEQ/BNE/BLT/BGE/BLTU/BGEU by iterating a 4-bit cascaded magnitude-compare slice over the operands, LSB nibble first. Each slice consumes the previous slice's eq/lt/gt cascade, so the final slice yields the full-width result. The unit sits between the decoder's register-read outputs and the PC-select logic. Valid/ready handshakes are used on both sides.

---
 rtl/branch_cmp_seq.sv | 176 +++++++++++++++++
 tb/tb_branch_cmp_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/branch_cmp_seq.sv
// branch_cmp_seq
//   Sequential RV32I branch-condition unit. It resolves BEQ/BNE/BLT/BGE/BLTU/BGEU
//   by walking a 4-bit cascaded magnitude-compare slice over the operands, least
//   significant nibble first. Each slice consumes the eq/lt/gt cascade of the
//   slice below it, so the most significant slice yields the full-width result.
//
// Optional feature (macro BRANCH_CMP_DUAL_NIB_EN):
//   When defined, two slices are chained per RUN cycle and latency drops from
//   XLEN/4 to XLEN/8 cycles. Results are identical in both modes.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  request handshake; in_ready is high only in IDLE
//   rs1, rs2, funct3     operands and branch funct3, sampled on the accept edge only
//   out_valid/out_ready  result handshake; results hold while out_ready is low
//   taken                branch condition true
//   eq, lt, gt           raw compare flags, signedness selected by funct3
//   illegal              funct3 was 010 or 011
//   busy                 state is RUN
//   state_dbg            current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake rule: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload stable while valid is high and
// ready is low; valid never waits on ready.

module branch_cmp_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic            eq,
  output logic            lt,
  output logic            gt,
  output logic            illegal,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  localparam int NIB = XLEN / 4;
  // One spare bit so the step constant and the wrap past the last nibble fit
  // even for the smallest legal XLEN.
  localparam int CW  = $clog2(NIB) + 1;
`ifdef BRANCH_CMP_DUAL_NIB_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam logic [CW-1:0] STEP_C = CW'(STEP);
  localparam logic [CW-1:0] LAST_C = CW'(NIB - STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] a_q, b_q;
  logic [2:0]      f3_q;
  logic [CW-1:0]   nib_cnt;
  logic            c_eq, c_lt, c_gt;
  logic [2:0]      casc_nx;
  logic            accept;
  logic            last_nib;
  logic            sgn;

  // One 4-bit cascaded compare slice. Returns {eq, lt, gt}.
  function automatic logic [2:0] slice(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] cin);
    logic same;
    same = (a == b);
    slice = {same & cin[2],
             (a < b) | (same & cin[1]),
             (a > b) | (same & cin[0])};
  endfunction

  assign accept   = in_valid && in_ready;
  assign last_nib = (nib_cnt == LAST_C);
  assign sgn      = (funct3[2:1] == 2'b10);

  // Cascade update for the current RUN cycle.
  always_comb begin
    casc_nx = slice(a_q[{nib_cnt, 2'b00} +: 4], b_q[{nib_cnt, 2'b00} +: 4],
                    {c_eq, c_lt, c_gt});
`ifdef BRANCH_CMP_DUAL_NIB_EN
    // nib_cnt is always even here, so nib_cnt|1 addresses the upper nibble.
    casc_nx = slice(a_q[{nib_cnt | CW'(1), 2'b00} +: 4],
                    b_q[{nib_cnt | CW'(1), 2'b00} +: 4], casc_nx);
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept)    state_nx = S_RUN;
      S_RUN:   if (last_nib)  state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default:                state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register only.
  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_RUN);
  assign out_valid = (state == S_DONE);
  assign state_dbg = state;

  // Datapath: operand latch, cascade walk and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      nib_cnt <= '0;
      c_eq    <= 1'b1;
      c_lt    <= 1'b0;
      c_gt    <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
      gt      <= 1'b0;
      taken   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            // Flipping the sign bit at latch time maps two's-complement order
            // onto unsigned order; only the top nibble ever sees that bit.
            a_q     <= rs1 ^ {sgn, {(XLEN-1){1'b0}}};
            b_q     <= rs2 ^ {sgn, {(XLEN-1){1'b0}}};
            f3_q    <= funct3;
            nib_cnt <= '0;
            c_eq    <= 1'b1;
            c_lt    <= 1'b0;
            c_gt    <= 1'b0;
          end
        end
        S_RUN: begin
          {c_eq, c_lt, c_gt} <= casc_nx;
          nib_cnt            <= nib_cnt + STEP_C;
          if (last_nib) begin
            {eq, lt, gt} <= casc_nx;
            illegal      <= 1'b0;
            case (f3_q)
              3'b000:         taken <= casc_nx[2];
              3'b001:         taken <= ~casc_nx[2];
              3'b100, 3'b110: taken <= casc_nx[1];
              3'b101, 3'b111: taken <= ~casc_nx[1];
              default: begin
                taken   <= 1'b0;
                illegal <= 1'b1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_cmp_seq.sv
// tb_branch_cmp_seq
//   Directed bench for branch_cmp_seq (XLEN=32). Each operation checks
//   acceptance, RUN latency, the result flags and the return to IDLE. Operand
//   inputs are scrambled right after the accept edge to show they are ignored.

module tb_branch_cmp_seq;

`ifdef BRANCH_CMP_DUAL_NIB_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        taken, eq, lt, gt, illegal, busy;
  logic [1:0]  state_dbg;

  int n_chk  = 0;
  int n_fail = 0;

  // Clock / reset
  always #5 clk = ~clk;

  branch_cmp_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .taken     (taken),
    .eq        (eq),
    .lt        (lt),
    .gt        (gt),
    .illegal   (illegal),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to completion.
  // exp_flags = {eq, lt, gt, taken, illegal}; hold = cycles of out_ready=0 in DONE.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, input logic [4:0] exp_flags, input int hold);
    @(negedge clk);
    chk({tag, " in_ready idle"}, in_ready, 1);
    rs1 = a; rs2 = b; funct3 = f; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom_range(0, 7));
    chk({tag, " busy"}, busy, 1);
    chk({tag, " state run"}, state_dbg, 1);
    for (int i = 1; i < LAT; i++) @(posedge clk);
    @(negedge clk);
    chk({tag, " out_valid early"}, out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " flags"}, {eq, lt, gt, taken, illegal}, exp_flags);
    if (hold > 0) begin
      in_valid = 1'b1; rs1 = a ^ 32'h1; funct3 = 3'b001;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, " hold out_valid"}, out_valid, 1);
        chk({tag, " hold flags"}, {eq, lt, gt, taken, illegal}, exp_flags);
        chk({tag, " hold in_ready"}, in_ready, 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, " out_valid drop"}, out_valid, 0);
    chk({tag, " back idle"}, in_ready, 1);
    chk({tag, " not busy"}, busy, 0);
  endtask

  // Watchdog: all waits are fixed-length, this only guards against a stuck clock.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    #12;
    chk("reset flags", {eq, lt, gt, taken, illegal}, 5'b0);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", in_ready, 1);
    chk("post-reset state", state_dbg, 0);

    // Directed operations: {eq, lt, gt, taken, illegal}
    run_op("beq_same",   32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 5'b10010, 0);
    run_op("blt_m1_1",   32'hFFFFFFFF, 32'h00000001, 3'b100, 5'b01010, 0);
    run_op("bltu_m1_1",  32'hFFFFFFFF, 32'h00000001, 3'b110, 5'b00100, 0);
    run_op("bge_min",    32'h80000000, 32'h80000000, 3'b101, 5'b10010, 0);
    run_op("bne_nib",    32'h00000010, 32'h00000001, 3'b001, 5'b00110, 0);
    run_op("illegal011", 32'h00000005, 32'h00000003, 3'b011, 5'b00101, 0);
    run_op("bgeu_0_max", 32'h00000000, 32'hFFFFFFFF, 3'b111, 5'b01000, 0);
    run_op("blt_max_min",32'h7FFFFFFF, 32'h80000000, 3'b100, 5'b00100, 0);
    run_op("bge_min_max",32'h80000000, 32'h7FFFFFFF, 3'b101, 5'b01000, 0);
    run_op("beq_lsb",    32'h12345678, 32'h12345679, 3'b000, 5'b01000, 0);
    run_op("illegal010", 32'h80000000, 32'h00000001, 3'b010, 5'b00101, 0);

    // Backpressure: result held for 5 cycles, second request refused.
    run_op("bp_bge",     32'h80000000, 32'h80000000, 3'b101, 5'b10010, 5);

    // Reset in the middle of RUN (previous result flags are nonzero here).
    run_op("pre_rst",    32'h00000002, 32'h00000001, 3'b001, 5'b00110, 0);
    @(negedge clk);
    rs1 = 32'h00000009; rs2 = 32'h00000001; funct3 = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(posedge clk);
    @(negedge clk);
    chk("mid-run busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst flags", {eq, lt, gt, taken, illegal}, 5'b0);
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst release in_ready", in_ready, 1);
    chk("rst release out_valid", out_valid, 0);
    run_op("bltu_1_2",   32'h00000001, 32'h00000002, 3'b110, 5'b01010, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
